brownout_ctrl: RTL and testbench
================================

BROWNOUT_CTRL -- requirements
Module: brownout_ctrl

Interface
REQ-001 SHALL have parameter STARTUP_CYC, default 1024, analog enable-to-valid startup time in ck cycles (range 2..4095).
REQ-002 SHALL have parameter SETTLE_CYC, default 64, trip-select settle/mask time in ck cycles (range 2..4095).
REQ-003 ck  input  1  single controller clock; all state changes on rising edge.
REQ-004 rsb  input  1  reset, asynchronous and active-low.
REQ-005 en_req  input  1  software request to run the brown-out detector, level.
REQ-006 cfg_wr  input  1  one-cycle strobe that loads vtrip_cfg/otrip_cfg.
REQ-007 vtrip_cfg  input  3  requested vtrip select.
REQ-008 otrip_cfg  input  3  requested otrip select.
REQ-009 irq_clr  input  1  one-cycle strobe clearing brout_irq.
REQ-010 outb  input  1  detector output, asynchronous, low = brown-out.
REQ-011 ena  output  1  analog detector enable.
REQ-012 vtrip  output  3  applied vtrip select, registered.
REQ-013 otrip  output  3  applied otrip select, registered.
REQ-014 ready  output  1  high only in ARMED or TRIPPED.
REQ-015 brout  output  1  high only in TRIPPED.
REQ-016 brout_irq  output  1  sticky brown-out interrupt.
REQ-017 event_cnt  output  8  saturating count of qualified brown-out events.

Function
REQ-018 outb SHALL pass a 2-flop synchronizer (reset value 1); outb_s is its output; no other logic SHALL sample outb directly.
REQ-019 States: OFF, STARTUP, SETTLE, ARMED, TRIPPED; one 12-bit down-counter cnt shared by STARTUP and SETTLE.
REQ-020 OFF: ena=0; en_req=1 -> STARTUP, cnt<=STARTUP_CYC-1.
REQ-021 STARTUP: ena=1; cnt decrements; cnt==0 -> SETTLE, cnt<=SETTLE_CYC-1.
REQ-022 SETTLE: ena=1; outb_s ignored; cnt decrements; cnt==0 -> ARMED.
REQ-023 ARMED: outb_s==0 -> TRIPPED; same edge brout_irq<=1 and event_cnt<=event_cnt+1 saturating at 255.
REQ-024 TRIPPED: outb_s==1 -> ARMED; no further count until re-entering TRIPPED.
REQ-025 Total latency outb falling -> brout_irq high SHALL be 3 ck edges in ARMED (2 sync + 1 state).
REQ-026 ena SHALL be 1 in every state except OFF, registered with state (no glitch).
REQ-027 cfg_wr SHALL load vtrip/otrip on the next edge in any state, including OFF.
REQ-028 cfg_wr in SETTLE, ARMED or TRIPPED -> SETTLE with cnt<=SETTLE_CYC-1 (re-mask); in STARTUP -> no state/cnt change; in OFF -> no state change.
REQ-029 en_req=0 in any non-OFF state -> OFF next edge, cnt<=0; brout_irq and event_cnt retained.
REQ-030 Priority per edge: en_req=0 > cfg_wr > outb_s trip/recover > counter expiry.
REQ-031 cfg_wr and outb_s falling same edge in ARMED: cfg_wr wins, event not counted, no irq.
REQ-032 irq_clr and new trip same edge: set wins, brout_irq stays 1.
REQ-033 irq_clr with no trip: brout_irq<=0 next edge; event_cnt never cleared except by reset.
REQ-034 en_req=1 in OFF with cfg_wr same edge: both take effect (STARTUP entered, selects loaded).

Reset
REQ-035 rsb low SHALL asynchronously force: state OFF, cnt 0, ena 0, vtrip 3'b000, otrip 3'b000, brout_irq 0, event_cnt 0, synchronizer flops 1; ready and brout follow as 0.
REQ-036 Reset mid-operation SHALL abandon the sequence; after release a new en_req=1 restarts full STARTUP.

Structure
REQ-037 State enum, counter width (12) and reset trip-select constants SHALL live in shared package brownout_pkg.
REQ-038 The synchronizer SHALL be sub-module brownout_sync (2 flops, async active-low reset to 1).

Verification
REQ-039 Reset, en_req=1, STARTUP_CYC=16, SETTLE_CYC=8 -> ena high 1 edge later, ready high exactly 24 edges after STARTUP entry.
REQ-040 In ARMED drive outb 1->0 -> brout_irq and brout high on 3rd edge, event_cnt 0->1; outb back to 1 -> brout low 3 edges later, irq stays 1.
REQ-041 256 trip pulses in ARMED (each >=3 cycles) -> event_cnt saturates at 255.
REQ-042 cfg_wr vtrip_cfg=5 in ARMED -> vtrip=5 next edge, ready low for SETTLE_CYC, outb low during mask -> no irq/count.
REQ-043 en_req dropped mid-STARTUP -> OFF and ena low next edge; rsb asserted in TRIPPED -> all outputs at reset values without a ck edge.
REQ-044 irq_clr coincident with trip edge -> brout_irq remains 1.

Source files
------------

// File: rtl/brownout_pkg.sv
// Shared constants for the brown-out controller: FSM encoding, counter
// width, reset trip selects, and the trip-select payload type.
package brownout_pkg;

  localparam int unsigned CNT_W = 12;
  localparam int unsigned EVT_W = 8;
  localparam int unsigned SEL_W = 3;

  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_STARTUP = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_ARMED   = 3'd3;
  localparam logic [2:0] ST_TRIPPED = 3'd4;

  localparam logic [SEL_W-1:0] VTRIP_RST = 3'b000;
  localparam logic [SEL_W-1:0] OTRIP_RST = 3'b000;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [SEL_W-1:0] vtrip;
    logic [SEL_W-1:0] otrip;
  } trip_sel_t;

  // Saturating event counter increment.
  function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
    return (v == {EVT_W{1'b1}}) ? v : v + EVT_W'(1);
  endfunction

endpackage

// File: rtl/brownout_if.sv
// Software/analog-side signals of the brown-out controller.
// master: drives requests, config and the detector output; slave: the controller.
interface brownout_if;
  logic                            en_req;
  logic                            cfg_wr;
  logic [brownout_pkg::SEL_W-1:0]  vtrip_cfg;
  logic [brownout_pkg::SEL_W-1:0]  otrip_cfg;
  logic                            irq_clr;
  logic                            outb;
  logic                            ena;
  logic [brownout_pkg::SEL_W-1:0]  vtrip;
  logic [brownout_pkg::SEL_W-1:0]  otrip;
  logic                            ready;
  logic                            brout;
  logic                            brout_irq;
  logic [brownout_pkg::EVT_W-1:0]  event_cnt;

  modport master (
    output en_req, cfg_wr, vtrip_cfg, otrip_cfg, irq_clr, outb,
    input  ena, vtrip, otrip, ready, brout, brout_irq, event_cnt
  );

  modport slave (
    input  en_req, cfg_wr, vtrip_cfg, otrip_cfg, irq_clr, outb,
    output ena, vtrip, otrip, ready, brout, brout_irq, event_cnt
  );
endinterface

// File: rtl/brownout_sync.sv
// Two-flop synchronizer for the asynchronous detector output.
// Ports: ck clock, rsb async active-low reset (flops reset to 1),
//        d async input, q synchronized output.
module brownout_sync (
  input  logic ck,
  input  logic rsb,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge ck or negedge rsb) begin
    if (!rsb) begin
      meta_q <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/brownout_ctrl.sv
// Brown-out detector controller: sequences analog startup and trip-select
// settling, then watches the synchronized detector output and raises a sticky
// interrupt and saturating event count on each qualified brown-out.
// Ports: ck clock, rsb async active-low reset, bus (slave) carrying
//        en_req/cfg_wr/vtrip_cfg/otrip_cfg/irq_clr/outb in and
//        ena/vtrip/otrip/ready/brout/brout_irq/event_cnt out (all registered).
module brownout_ctrl
  import brownout_pkg::*;
#(
  parameter int unsigned STARTUP_CYC = 1024,
  parameter int unsigned SETTLE_CYC  = 64
) (
  input  logic       ck,
  input  logic       rsb,
  brownout_if.slave  bus
);

  localparam cnt_t STARTUP_LD = CNT_W'(STARTUP_CYC - 1);
  localparam cnt_t SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);

  logic             outb_s;
  logic [2:0]       state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  trip_sel_t        sel_q, sel_d;
  logic             irq_q, irq_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic             ena_q, ena_d;
  logic             ready_q, ready_d;
  logic             brout_q, brout_d;

  brownout_sync u_sync (
    .ck  (ck),
    .rsb (rsb),
    .d   (bus.outb),
    .q   (outb_s)
  );

  // State and registered outputs.
  always_ff @(posedge ck or negedge rsb) begin
    if (!rsb) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      sel_q   <= '{vtrip: VTRIP_RST, otrip: OTRIP_RST};
      irq_q   <= 1'b0;
      evt_q   <= '0;
      ena_q   <= 1'b0;
      ready_q <= 1'b0;
      brout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      irq_q   <= irq_d;
      evt_q   <= evt_d;
      ena_q   <= ena_d;
      ready_q <= ready_d;
      brout_q <= brout_d;
    end
  end

  // Next state; priority: disable > config write > trip/recover > expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    irq_d   = irq_q;
    evt_d   = evt_q;

    if (bus.cfg_wr) begin
      sel_d.vtrip = bus.vtrip_cfg;
      sel_d.otrip = bus.otrip_cfg;
    end
    // A trip on the same edge overrides this below.
    if (bus.irq_clr) irq_d = 1'b0;

    if (state_q == ST_OFF) begin
      if (bus.en_req) begin
        state_d = ST_STARTUP;
        cnt_d   = STARTUP_LD;
      end
    end else if (!bus.en_req) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else if (bus.cfg_wr) begin
      // New selects need re-masking; startup timing is left untouched.
      if (state_q != ST_STARTUP) begin
        state_d = ST_SETTLE;
        cnt_d   = SETTLE_LD;
      end
    end else begin
      case (state_q)
        ST_STARTUP: begin
          if (cnt_q == '0) begin
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) state_d = ST_ARMED;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_ARMED: begin
          if (!outb_s) begin
            state_d = ST_TRIPPED;
            irq_d   = 1'b1;
            evt_d   = sat_inc(evt_q);
          end
        end
        ST_TRIPPED: begin
          if (outb_s) state_d = ST_ARMED;
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end

    ena_d   = (state_d != ST_OFF);
    ready_d = (state_d == ST_ARMED) || (state_d == ST_TRIPPED);
    brout_d = (state_d == ST_TRIPPED);
  end

  assign bus.ena       = ena_q;
  assign bus.vtrip     = sel_q.vtrip;
  assign bus.otrip     = sel_q.otrip;
  assign bus.ready     = ready_q;
  assign bus.brout     = brout_q;
  assign bus.brout_irq = irq_q;
  assign bus.event_cnt = evt_q;

endmodule

// File: tb/tb_brownout_ctrl.sv
// Bench for brownout_ctrl with STARTUP_CYC=16, SETTLE_CYC=8.
module tb_brownout_ctrl;

  logic ck;
  logic rsb;
  int   total;
  int   bad;

  brownout_if bus ();

  brownout_ctrl #(
    .STARTUP_CYC (16),
    .SETTLE_CYC  (8)
  ) dut (
    .ck  (ck),
    .rsb (rsb),
    .bus (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One table row: inputs for one edge and outputs expected right after it.
  typedef struct packed {
    logic       cfg_wr;
    logic [2:0] vcfg;
    logic [2:0] ocfg;
    logic       clr;
    logic       outb;
    logic       ready;
    logic       brout;
    logic       irq;
    logic [2:0] vtrip;
    logic [2:0] otrip;
    logic [7:0] cnt;
  } vec_t;

  localparam int NVEC = 33;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic c, input logic [2:0] vc, input logic [2:0] oc,
                              input logic cl, input logic ob, input logic rd,
                              input logic br, input logic iq, input logic [2:0] vt,
                              input logic [2:0] ot, input logic [7:0] n);
    vec_t v;
    v.cfg_wr = c;  v.vcfg = vc;  v.ocfg = oc;  v.clr = cl;  v.outb = ob;
    v.ready = rd;  v.brout = br; v.irq = iq;   v.vtrip = vt; v.otrip = ot;
    v.cnt = n;
    return v;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cfg_wr    = 1'b0;
    bus.vtrip_cfg = 3'd0;
    bus.otrip_cfg = 3'd0;
    bus.irq_clr   = 1'b0;
  endtask

  // Counts edges until ready rises; a missing rise shows up as a count mismatch.
  task automatic wait_ready(input string name, input int exp_edges);
    int n;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      n = i;
      if (bus.ready) break;
    end
    if (!bus.ready) n = 999;
    check(name, n, exp_edges);
  endtask

  task automatic check_all(input string tag, input int ena, input int vt, input int ot,
                           input int rd, input int br, input int iq, input int n);
    check({tag, ".ena"},       int'(bus.ena),       ena);
    check({tag, ".vtrip"},     int'(bus.vtrip),     vt);
    check({tag, ".otrip"},     int'(bus.otrip),     ot);
    check({tag, ".ready"},     int'(bus.ready),     rd);
    check({tag, ".brout"},     int'(bus.brout),     br);
    check({tag, ".brout_irq"}, int'(bus.brout_irq), iq);
    check({tag, ".event_cnt"}, int'(bus.event_cnt), n);
  endtask

  initial begin
    int exp_cnt;
    total = 0;
    bad   = 0;

    // ARMED-state vectors, starting from vtrip=2 otrip=6, count 0, outb high.
    vecs[0]  = mk(0,0,0,0,0, 1,0,0,2,6,0);
    vecs[1]  = mk(0,0,0,0,0, 1,0,0,2,6,0);
    vecs[2]  = mk(0,0,0,0,0, 1,1,1,2,6,1);  // 3rd edge after outb fell
    vecs[3]  = mk(0,0,0,0,1, 1,1,1,2,6,1);
    vecs[4]  = mk(0,0,0,0,1, 1,1,1,2,6,1);
    vecs[5]  = mk(0,0,0,0,1, 1,0,1,2,6,1);  // recovered, irq sticky
    vecs[6]  = mk(0,0,0,1,1, 1,0,0,2,6,1);  // irq_clr
    vecs[7]  = mk(0,0,0,0,0, 1,0,0,2,6,1);
    vecs[8]  = mk(0,0,0,0,0, 1,0,0,2,6,1);
    vecs[9]  = mk(0,0,0,1,0, 1,1,1,2,6,2);  // clear vs trip: set wins
    vecs[10] = mk(0,0,0,1,1, 1,1,0,2,6,2);  // clear while tripped
    vecs[11] = mk(0,0,0,0,1, 1,1,0,2,6,2);
    vecs[12] = mk(0,0,0,0,1, 1,0,0,2,6,2);
    vecs[13] = mk(1,5,1,0,0, 0,0,0,5,1,2);  // cfg_wr re-masks
    for (int i = 14; i <= 19; i++) vecs[i] = mk(0,0,0,0,0, 0,0,0,5,1,2);
    vecs[20] = mk(0,0,0,0,1, 0,0,0,5,1,2);
    vecs[21] = mk(0,0,0,0,1, 1,0,0,5,1,2);  // SETTLE_CYC edges later
    vecs[22] = mk(0,0,0,0,0, 1,0,0,5,1,2);
    vecs[23] = mk(0,0,0,0,0, 1,0,0,5,1,2);
    vecs[24] = mk(1,3,3,0,0, 0,0,0,3,3,2);  // cfg_wr beats trip same edge
    for (int i = 25; i <= 31; i++) vecs[i] = mk(0,0,0,0,1, 0,0,0,3,3,2);
    vecs[32] = mk(0,0,0,0,1, 1,0,0,3,3,2);

    // Reset
    rsb        = 1'b0;
    bus.en_req = 1'b0;
    bus.outb   = 1'b1;
    idle_inputs();
    repeat (2) step();
    check_all("reset", 0, 0, 0, 0, 0, 0, 0);
    rsb = 1'b1;
    step();
    check("off_idle.ena", int'(bus.ena), 0);

    // en_req and cfg_wr together in OFF
    bus.en_req    = 1'b1;
    bus.cfg_wr    = 1'b1;
    bus.vtrip_cfg = 3'd2;
    bus.otrip_cfg = 3'd6;
    step();
    idle_inputs();
    check_all("startup_entry", 1, 2, 6, 0, 0, 0, 0);
    wait_ready("startup_to_ready_edges", 24);

    // Table-driven ARMED/TRIPPED/SETTLE sequence
    for (int i = 0; i < NVEC; i++) begin
      bus.cfg_wr    = vecs[i].cfg_wr;
      bus.vtrip_cfg = vecs[i].vcfg;
      bus.otrip_cfg = vecs[i].ocfg;
      bus.irq_clr   = vecs[i].clr;
      bus.outb      = vecs[i].outb;
      step();
      check($sformatf("vec%0d.ready", i), int'(bus.ready),     int'(vecs[i].ready));
      check($sformatf("vec%0d.brout", i), int'(bus.brout),     int'(vecs[i].brout));
      check($sformatf("vec%0d.irq",   i), int'(bus.brout_irq), int'(vecs[i].irq));
      check($sformatf("vec%0d.vtrip", i), int'(bus.vtrip),     int'(vecs[i].vtrip));
      check($sformatf("vec%0d.otrip", i), int'(bus.otrip),     int'(vecs[i].otrip));
      check($sformatf("vec%0d.cnt",   i), int'(bus.event_cnt), int'(vecs[i].cnt));
      check($sformatf("vec%0d.ena",   i), int'(bus.ena),       1);
    end
    idle_inputs();

    // 256 trip pulses: count saturates at 255
    exp_cnt = 2;
    for (int k = 0; k < 256; k++) begin
      bus.outb = 1'b0;
      repeat (3) step();
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      check($sformatf("sat_pulse%0d.brout", k), int'(bus.brout), 1);
      check($sformatf("sat_pulse%0d.cnt", k), int'(bus.event_cnt), exp_cnt);
      bus.outb = 1'b1;
      repeat (3) step();
    end
    check("sat_final.brout", int'(bus.brout), 0);
    check("sat_final.cnt", int'(bus.event_cnt), 255);

    // en_req dropped in ARMED: OFF, irq and count retained
    bus.en_req = 1'b0;
    step();
    check_all("disable_armed", 0, 3, 3, 0, 0, 1, 255);

    // cfg_wr in OFF loads selects without leaving OFF
    bus.cfg_wr    = 1'b1;
    bus.vtrip_cfg = 3'd7;
    bus.otrip_cfg = 3'd4;
    step();
    idle_inputs();
    check_all("cfg_in_off", 0, 7, 4, 0, 0, 1, 255);

    // en_req dropped mid-STARTUP
    bus.en_req = 1'b1;
    step();
    check("mid_startup.ena_on", int'(bus.ena), 1);
    repeat (5) step();
    bus.en_req = 1'b0;
    step();
    check("mid_startup_drop.ena", int'(bus.ena), 0);
    check("mid_startup_drop.ready", int'(bus.ready), 0);

    // Restart, trip, then async reset while TRIPPED
    bus.en_req = 1'b1;
    step();
    wait_ready("restart_ready_edges", 24);
    bus.outb = 1'b0;
    repeat (3) step();
    check("pre_reset.brout", int'(bus.brout), 1);
    #2;
    rsb = 1'b0;
    #1;
    check_all("async_reset_tripped", 0, 0, 0, 0, 0, 0, 0);
    bus.outb   = 1'b1;
    bus.en_req = 1'b0;
    step();
    rsb = 1'b1;
    step();
    check("post_reset.ena", int'(bus.ena), 0);

    // Full startup again after reset
    bus.en_req = 1'b1;
    step();
    check("post_reset_startup.ena", int'(bus.ena), 1);
    wait_ready("post_reset_ready_edges", 24);
    check("post_reset.cnt", int'(bus.event_cnt), 0);
    check("post_reset.irq", int'(bus.brout_irq), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
